// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ w_clk-domain clients.
// Define FIFO_WARB_BURST_EN to let an owner keep the grant for up to MAX_BURST accepted words.
module fifo_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4,
    parameter int IW        = $clog2(NREQ)
) (
    input  logic               w_clk,
    input  logic               w_reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               full,
    output logic [NREQ-1:0]    ack,
    output logic               w_en,
    output logic [DW-1:0]      w_data,
    output logic [IW-1:0]      owner,
    output logic               busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] last, last_nx, owner_nx, base, winner;
    logic [3:0]    bcnt, bcnt_nx;
    logic          any_req, found, burst_end, release_g;
    int            idx;

    if (NREQ < 2 || NREQ > 8 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_cfg
        $error("fifo_write_arbiter: unsupported NREQ/MAX_BURST");
    end

    assign any_req = |req;
    assign busy    = (state == BUSY);
    assign w_en    = busy & req[owner] & ~full;
    assign w_data  = req_data[int'(owner)*DW +: DW];

    for (genvar i = 0; i < NREQ; i++) begin : g_ack
        assign ack[i] = w_en & (owner == IW'(i));
    end

    // Releasing owner is the search base, so it ends up with lowest priority.
    assign base = busy ? owner : last;

    always_comb begin
        winner = base;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(base) + k) % NREQ;
            if (!found && req[idx]) begin
                winner = IW'(idx);
                found  = 1'b1;
            end
        end
    end

`ifdef FIFO_WARB_BURST_EN
    assign burst_end = (bcnt == 4'(MAX_BURST-1));
`else
    assign burst_end = 1'b1;
`endif

    assign release_g = (w_en & burst_end) | ~req[owner];

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last;
        bcnt_nx  = bcnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = BUSY;
                    owner_nx = winner;
                    bcnt_nx  = 4'd0;
                end
            end
            BUSY: begin
                if (release_g) begin
                    last_nx = owner;
                    bcnt_nx = 4'd0;
                    if (any_req) owner_nx = winner;
                    else         state_nx = IDLE;
                end else if (w_en) begin
`ifdef FIFO_WARB_BURST_EN
                    if (bcnt != 4'(MAX_BURST-1)) bcnt_nx = bcnt + 4'd1;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge w_clk or negedge w_reset) begin
        if (!w_reset) begin
            state <= IDLE;
            owner <= '0;
            last  <= IW'(NREQ-1);
            bcnt  <= 4'd0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            last  <= last_nx;
            bcnt  <= bcnt_nx;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboarded bench for fifo_write_arbiter: per-cycle expected write owner (-1 = no write).
`timescale 1ns/1ps
module tb_fifo_write_arbiter;

    localparam int NREQ = 4, DW = 8, MAX_BURST = 4, IW = 2;
`ifdef FIFO_WARB_BURST_EN
    localparam int BL = MAX_BURST;
`else
    localparam int BL = 1;
`endif

    logic               w_clk = 1'b0;
    logic               w_reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic               full;
    logic [NREQ-1:0]    ack;
    logic               w_en;
    logic [DW-1:0]      w_data;
    logic [IW-1:0]      owner;
    logic               busy;

    typedef struct { int idx; logic [DW-1:0] data; } exp_t;
    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    fifo_write_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .w_clk(w_clk), .w_reset(w_reset), .req(req), .req_data(req_data), .full(full),
        .ack(ack), .w_en(w_en), .w_data(w_data), .owner(owner), .busy(busy)
    );

    always #5 w_clk = ~w_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1);
    end

    function automatic logic [DW-1:0] slice(input logic [NREQ*DW-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        w_reset = 1'b0; req = '0; full = 1'b0;
        tick();
        w_reset = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        w_reset = 1'b0; full = 1'b0; req = 4'b1010;
        req_data = {8'h44, 8'h33, 8'h22, 8'h5A};
        #2;
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (w_en !== 1'b0)  begin bad++; $display("FAIL reset_wen: got %b want 0", w_en); end
        total++; if (ack !== 4'b0)   begin bad++; $display("FAIL reset_ack: got %b want 0000", ack); end
        total++; if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner: got %0d want 0", owner); end
        total++; if (w_data !== 8'h5A) begin bad++; $display("FAIL reset_wdata: got %h want 5a", w_data); end
        repeat (2) tick();
        w_reset = 1'b1; req = '0;
    endtask

    task automatic test_single();
        logic [3:0] rq [3] = '{4'b0001, 4'b0001, 4'b0000};
        int         ex [3] = '{-1, 0, -1};
        do_reset();
        req_data = {8'h44, 8'h33, 8'h22, 8'hA5};
        for (int c = 0; c < 3; c++) sb.push_back('{ex[c], slice(req_data, ex[c] < 0 ? 0 : ex[c])});
        for (int c = 0; c < 3; c++) begin
            tick();
            req = rq[c];
            #1;
            e = sb.pop_front();
            total++;
            if (e.idx < 0) begin
                if (w_en !== 1'b0 || ack !== 4'b0) begin bad++; $display("FAIL single c%0d: w_en=%b ack=%b want idle", c, w_en, ack); end
            end else if (w_en !== 1'b1 || ack !== (4'b0001 << e.idx) || w_data !== e.data) begin
                bad++; $display("FAIL single c%0d: w_en=%b ack=%b data=%h want ack=%b data=%h", c, w_en, ack, w_data, 4'b0001 << e.idx, e.data);
            end
            if (c == 1) begin
                total++; if (busy !== 1'b1 || owner !== 2'd0) begin bad++; $display("FAIL single_grant: busy=%b owner=%0d want 1/0", busy, owner); end
            end
        end
        tick();
        total++; if (busy !== 1'b0 || sb.size() != 0) begin bad++; $display("FAIL single_end: busy=%b left=%0d want 0/0", busy, sb.size()); end
    endtask

    task automatic test_round_robin();
        int w = 2 * NREQ * BL;
        do_reset();
        req_data = {8'h4D, 8'h3C, 8'h2B, 8'h1A};
        sb.push_back('{-1, 8'h00});
        for (int c = 1; c <= w; c++) sb.push_back('{((c-1)/BL) % NREQ, slice(req_data, ((c-1)/BL) % NREQ)});
        sb.push_back('{-1, 8'h00});
        for (int c = 0; c <= w + 1; c++) begin
            tick();
            req = (c <= w) ? 4'b1111 : 4'b0000;
            #1;
            e = sb.pop_front();
            total++;
            if (e.idx < 0) begin
                if (w_en !== 1'b0 || ack !== 4'b0) begin bad++; $display("FAIL rr c%0d: w_en=%b ack=%b want idle", c, w_en, ack); end
            end else if (w_en !== 1'b1 || ack !== (4'b0001 << e.idx) || w_data !== e.data || owner !== IW'(e.idx)) begin
                bad++; $display("FAIL rr c%0d: w_en=%b ack=%b owner=%0d data=%h want owner=%0d data=%h", c, w_en, ack, owner, w_data, e.idx, e.data);
            end
        end
        tick();
        total++; if (busy !== 1'b0 || sb.size() != 0) begin bad++; $display("FAIL rr_end: busy=%b left=%0d want 0/0", busy, sb.size()); end
    endtask

    task automatic test_full_stall();
        logic [3:0] rq [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        logic       fl [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int         ex [7] = '{-1, 2, -1, -1, -1, 2, -1};
        do_reset();
        req_data = {8'h4D, 8'h77, 8'h2B, 8'h1A};
        for (int c = 0; c < 7; c++) sb.push_back('{ex[c], slice(req_data, ex[c] < 0 ? 0 : ex[c])});
        for (int c = 0; c < 7; c++) begin
            tick();
            req = rq[c]; full = fl[c];
            #1;
            e = sb.pop_front();
            total++;
            if (e.idx < 0) begin
                if (w_en !== 1'b0 || ack !== 4'b0) begin bad++; $display("FAIL stall c%0d: w_en=%b ack=%b want idle", c, w_en, ack); end
            end else if (w_en !== 1'b1 || ack !== (4'b0001 << e.idx) || w_data !== e.data) begin
                bad++; $display("FAIL stall c%0d: w_en=%b ack=%b data=%h want ack=%b data=%h", c, w_en, ack, w_data, 4'b0001 << e.idx, e.data);
            end
            if (c >= 2 && c <= 4) begin
                total++; if (busy !== 1'b1 || owner !== 2'd2) begin bad++; $display("FAIL stall_hold c%0d: busy=%b owner=%0d want 1/2", c, busy, owner); end
            end
        end
        tick();
        full = 1'b0;
        total++; if (busy !== 1'b0 || sb.size() != 0) begin bad++; $display("FAIL stall_end: busy=%b left=%0d want 0/0", busy, sb.size()); end
    endtask

    task automatic test_withdraw();
        logic [3:0] rq [8] = '{4'b1010, 4'b1010, 4'b1000, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0000};
`ifdef FIFO_WARB_BURST_EN
        int         ex [8] = '{-1, 1, -1, 3, 3, 3, 3, -1};
`else
        int         ex [8] = '{-1, 1, 3, 3, 1, 3, 1, -1};
`endif
        do_reset();
        req_data = {8'h83, 8'h3C, 8'h21, 8'h1A};
        for (int c = 0; c < 8; c++) sb.push_back('{ex[c], slice(req_data, ex[c] < 0 ? 0 : ex[c])});
        for (int c = 0; c < 8; c++) begin
            tick();
            req = rq[c];
            #1;
            e = sb.pop_front();
            total++;
            if (e.idx < 0) begin
                if (w_en !== 1'b0 || ack !== 4'b0) begin bad++; $display("FAIL withdraw c%0d: w_en=%b ack=%b want idle", c, w_en, ack); end
            end else if (w_en !== 1'b1 || ack !== (4'b0001 << e.idx) || w_data !== e.data) begin
                bad++; $display("FAIL withdraw c%0d: w_en=%b ack=%b data=%h want ack=%b data=%h", c, w_en, ack, w_data, 4'b0001 << e.idx, e.data);
            end
            if (c == 3) begin
                total++; if (owner !== 2'd3) begin bad++; $display("FAIL withdraw_owner: got %0d want 3", owner); end
            end
        end
        tick();
        total++; if (busy !== 1'b0 || sb.size() != 0) begin bad++; $display("FAIL withdraw_end: busy=%b left=%0d want 0/0", busy, sb.size()); end
    endtask

    task automatic test_reset_mid_busy();
        logic [3:0] rq [7] = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0000};
        logic       rs [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int         ex [7] = '{-1, 3, -1, -1, -1, 0, -1};
        do_reset();
        req_data = {8'h9C, 8'h3C, 8'h2B, 8'h61};
        for (int c = 0; c < 7; c++) sb.push_back('{ex[c], slice(req_data, ex[c] < 0 ? 0 : ex[c])});
        for (int c = 0; c < 7; c++) begin
            tick();
            req = rq[c]; w_reset = rs[c];
            #1;
            e = sb.pop_front();
            total++;
            if (e.idx < 0) begin
                if (w_en !== 1'b0 || ack !== 4'b0) begin bad++; $display("FAIL rstbusy c%0d: w_en=%b ack=%b want idle", c, w_en, ack); end
            end else if (w_en !== 1'b1 || ack !== (4'b0001 << e.idx) || w_data !== e.data || owner !== IW'(e.idx)) begin
                bad++; $display("FAIL rstbusy c%0d: w_en=%b ack=%b owner=%0d data=%h want owner=%0d data=%h", c, w_en, ack, owner, w_data, e.idx, e.data);
            end
            if (c == 2) begin
                total++; if (busy !== 1'b0 || owner !== 2'd0) begin bad++; $display("FAIL rstbusy_async: busy=%b owner=%0d want 0/0", busy, owner); end
            end
        end
        tick();
        total++; if (busy !== 1'b0 || sb.size() != 0) begin bad++; $display("FAIL rstbusy_end: busy=%b left=%0d want 0/0", busy, sb.size()); end
    endtask

    initial begin
        w_reset = 1'b0; req = '0; full = 1'b0; req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_withdraw();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
